// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only while idle
//   kill     synchronous abort, back to idle on the next edge
//   func3    M-extension operation select (MUL..REMU)
//   op_a     rs1 (multiplicand / dividend)
//   op_b     rs2 (multiplier / divisor)
//   busy     high while an operation is in flight, including the done cycle
//   done     one-cycle pulse, result valid in the same cycle
//   result   final value, held until a new operation completes
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // ARM registers the sign/special-case flags so the wide zero and MIN
  // compares do not sit in series with the negation done in PREP.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] ITER     = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [2:0]        fn;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   mb;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;      // product, or dividend/quotient shifter in the low half
  logic [XLEN-1:0]   rem;      // partial remainder; top bit of the XLEN+1 step is always 0 after restore
  logic [CNT_W-1:0]  cnt;
  logic              neg_a;
  logic              neg_b;
  logic              b_zero;
  logic              div_ovf;

  logic              is_div;
  logic              a_signed;
  logic              b_signed;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;
  logic [XLEN-1:0]   special_val;

  always_comb begin
    is_div   = fn[2];
    // MUL is run unsigned: the low half of the product does not depend on signedness.
    a_signed = (fn == F_MULH) || (fn == F_MULHSU) || (fn == F_DIV) || (fn == F_REM);
    b_signed = (fn == F_MULH) || (fn == F_DIV) || (fn == F_REM);

    mag_a = neg_a ? -a_q : a_q;
    mag_b = neg_b ? -b_q : b_q;

    // Shift-add: conditionally add the multiplicand into the high half, keep the carry.
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});

    // Restoring step: a clear top bit of the difference means the divisor fits.
    rem_sh   = {rem, acc[XLEN-1]};
    rem_diff = rem_sh - {1'b0, mb};

    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_a ? -rem : rem;

    case (fn)
      F_MUL:                      fix_val = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              fix_val = quo_fix;
      default:                    fix_val = rem_fix;
    endcase

    // fn[1] separates REM/REMU from DIV/DIVU.
    if (b_zero) begin
      special_val = fn[1] ? a_q : ONES;
    end else begin
      special_val = fn[1] ? {XLEN{1'b0}} : MIN_VAL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      fn      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mb      <= '0;
      acc     <= '0;
      rem     <= '0;
      cnt     <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      b_zero  <= 1'b0;
      div_ovf <= 1'b0;
    end else if (kill && (state != S_IDLE)) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !kill) begin
            fn    <= func3;
            a_q   <= op_a;
            b_q   <= op_b;
            busy  <= 1'b1;
            state <= S_ARM;
          end
        end

        S_ARM: begin
          neg_a   <= a_signed & a_q[XLEN-1];
          neg_b   <= b_signed & b_q[XLEN-1];
          b_zero  <= (b_q == '0);
          div_ovf <= ((fn == F_DIV) || (fn == F_REM)) && (a_q == MIN_VAL) && (b_q == ONES);
          state   <= S_PREP;
        end

        S_PREP: begin
          cnt <= ITER;
          rem <= '0;
          if (is_div) begin
            mb  <= mag_b;
            acc <= {{XLEN{1'b0}}, mag_a};
          end else begin
            mb  <= mag_a;
            acc <= {{XLEN{1'b0}}, mag_b};
          end
          if (is_div && (b_zero || div_ovf)) begin
            result <= special_val;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end

        S_CALC: begin
          if (is_div) begin
            if (!rem_diff[XLEN]) begin
              rem           <= rem_diff[XLEN-1:0];
              acc[XLEN-1:0] <= {acc[XLEN-2:0], 1'b1};
            end else begin
              rem           <= rem_sh[XLEN-1:0];
              acc[XLEN-1:0] <= {acc[XLEN-2:0], 1'b0};
            end
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
          end
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          state  <= S_DONE;
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        kill;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp = 32'd0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .kill    (kill),
    .func3   (func3),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p, t;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p = '0;
    t = '0;
    r = '0;
    case (f)
      3'b000: p = ua * ub;
      3'b001: p = sa * sb;
      3'b010: p = sa * longint'(ub);
      3'b011: p = ua * ub;
      default: p = '0;
    endcase
    case (f)
      3'b000: r = p[31:0];
      3'b001, 3'b010, 3'b011: r = p[63:32];
      3'b100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin t = sa / sb; r = t[31:0]; end
      end
      3'b101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin t = sa % sb; r = t[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 35;
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cnt, output bit timeout);
    func3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    func3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = -1; busy_cnt = 0; timeout = 1'b1; res = '0;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) @(negedge clk);
      if (done) begin
        lat = n; res = result; timeout = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  fs [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [31:0] as [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] res; int lat, bc; bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(fs[i], as[i], bs[i], res, lat, bc, to);
      checks++; if (to) begin errors++; $display("FAIL mul_timeout[%0d]: no done within 100 cycles", i); end
      checks++; if (res !== es[i]) begin errors++; $display("FAIL mul_result[%0d]: got %h expected %h", i, res, es[i]); end
      checks++; if (lat != 35) begin errors++; $display("FAIL mul_latency[%0d]: got %0d expected 35", i, lat); end
      if (i == 0) begin
        checks++; if (bc != 35) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 35", bc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_done: got %b expected 1", busy); end
      end
      last_exp = es[i];
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mul_after_done[%0d]: busy %b done %b expected 0 0", i, busy, done); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] es [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res; int lat, bc; bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(fs[i], as[i], bs[i], res, lat, bc, to);
      checks++; if (res !== es[i]) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, es[i]); end
      checks++; if (lat != 35) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 35", i, lat); end
      last_exp = es[i];
      @(negedge clk);
    end
  endtask

  task automatic test_special();
    logic [2:0]  fs [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res; int lat, bc; bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(fs[i], as[i], bs[i], res, lat, bc, to);
      checks++; if (res !== es[i]) begin errors++; $display("FAIL special_result[%0d]: got %h expected %h", i, res, es[i]); end
      checks++; if (lat != 2) begin errors++; $display("FAIL special_latency[%0d]: got %0d expected 2", i, lat); end
      last_exp = es[i];
      @(negedge clk);
    end
  endtask

  task automatic test_start_kill_idle();
    func3 = 3'b000; op_a = 32'd3; op_b = 32'd4; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_kill_idle_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_kill_idle_later: busy %b done %b expected 0 0", busy, done); end
  endtask

  task automatic test_kill();
    bit seen;
    func3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL kill_done: got %b expected 0", done); end
    checks++; if (result !== last_exp) begin errors++; $display("FAIL kill_result: got %h expected %h", result, last_exp); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL kill_no_done: got done pulse expected none"); end
    checks++; if (result !== last_exp) begin errors++; $display("FAIL kill_result_held: got %h expected %h", result, last_exp); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    func3 = 3'b011; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL reset_mid: busy %b done %b result %h expected 0 0 0", busy, done, result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    last_exp = 32'd0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL reset_mid_quiet: got activity expected idle"); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res; int lat;
    func3 = 3'b111; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1; res = '0;
    for (int n = 1; n < 100; n++) begin
      @(negedge clk);
      if (done) begin lat = n; res = result; break; end
      if (n >= 3 && n <= 8) begin
        start = 1'b1; func3 = 3'b000; op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL busy_start_result: got %h expected 00000002", res); end
    checks++; if (lat != 35) begin errors++; $display("FAIL busy_start_latency: got %0d expected 35", lat); end
    last_exp = 32'd2;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_relaunch: got busy %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat, bc; bit to;
    logic [31:0] e1, e2;
    e1 = ref_model(3'b000, 32'd12345, 32'd678);
    e2 = ref_model(3'b100, 32'hFFFF_0000, 32'd9);
    do_op(3'b000, 32'd12345, 32'd678, res, lat, bc, to);
    checks++; if (res !== e1 || lat != 35) begin errors++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 35", res, lat, e1); end
    @(negedge clk);
    do_op(3'b100, 32'hFFFF_0000, 32'd9, res, lat, bc, to);
    checks++; if (res !== e2 || lat != 35) begin errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 35", res, lat, e2); end
    last_exp = e2;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] res, a, b, e; logic [2:0] f; int lat, bc, el; bit to;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      e = ref_model(f, a, b);
      el = ref_latency(f, a, b);
      do_op(f, a, b, res, lat, bc, to);
      checks++; if (res !== e) begin errors++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, e); end
      checks++; if (lat != el) begin errors++; $display("FAIL rand_latency[%0d] f=%0d: got %0d expected %0d", i, f, lat, el); end
      last_exp = e;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; kill = 1'b0; func3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_kill_idle();
    test_kill();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
